hex_digit_sequencer: RTL and testbench

- Controller that sits in front of a single hex 7-segment decoder/display slot.
- Captures switch nibbles into a small digit buffer on a load strobe.
- Plays the buffer back one digit at a time on the shared decoder, with a timed blank gap between digits.
- Drives the decoder's 4-bit input plus a blank control; the decoder and the LEDR mirror stay outside this block.

---
 rtl/hex_digit_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_hex_digit_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_sequencer.sv
// hex_digit_sequencer: captures switch nibbles into a small digit buffer and
// plays them back one at a time on a single shared hex 7-segment decoder,
// with a timed blank gap between consecutive digits.
//
// Ports:
//   input_clock_50   system clock, rising edge
//   input_reset      synchronous active-high reset
//   input_nibble     digit value to append (SW3 = MSB)
//   input_load       one-cycle strobe: append input_nibble (IDLE only)
//   input_run        level: 1 = play back buffer, 0 = stop
//   input_clear      one-cycle strobe: empty the buffer
//   output_digit     nibble presented to the decoder
//   output_blank     1 = decoder drives all segments off
//   output_index     buffer slot currently shown
//   output_count     number of valid digits
//   output_full      count == DEPTH (combinational from count)
//   output_overflow  one-cycle pulse when a load is rejected
module hex_digit_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                         input_clock_50,
    input  logic                         input_reset,
    input  logic [3:0]                   input_nibble,
    input  logic                         input_load,
    input  logic                         input_run,
    input  logic                         input_clear,
    output logic [3:0]                   output_digit,
    output logic                         output_blank,
    output logic [$clog2(DEPTH)-1:0]     output_index,
    output logic [$clog2(DEPTH+1)-1:0]   output_count,
    output logic                         output_full,
    output logic                         output_overflow
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   index_q, index_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      digit_q, digit_d;
    logic            blank_q, blank_d;
    logic            ovf_q,   ovf_d;
    logic            wr_en;
    logic            presc_end;
    logic            last_slot;
    logic [IW-1:0]   last_idx;
    logic [3:0]      buf_q [DEPTH];

    assign presc_end = (presc_q == PW'(TICK_DIV - 1));
    // Current slot is the last valid one, so playback wraps to slot 0
    assign last_slot = ((CW'(index_q) + CW'(1)) == count_q);

    // State and datapath registers
    always_ff @(posedge input_clock_50) begin
        if (input_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            index_q <= '0;
            presc_q <= '0;
            digit_q <= '0;
            blank_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            blank_q <= blank_d;
            ovf_q   <= ovf_d;
        end
    end

    // Digit buffer; contents intentionally survive reset
    always_ff @(posedge input_clock_50) begin
        if (wr_en && !input_reset) begin
            buf_q[IW'(count_q)] <= input_nibble;
        end
    end

    // Next-state logic; precedence: clear, run = 0, load, terminal count
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        presc_d = presc_q;
        wr_en   = 1'b0;
        ovf_d   = 1'b0;

        if (input_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            index_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (input_load) begin
                        if (count_q < CW'(DEPTH)) begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (input_run && (count_q != '0)) begin
                        state_d = ST_SHOW;
                        index_d = '0;
                        presc_d = '0;
                    end
                end
                ST_SHOW, ST_GAP: begin
                    if (!input_run) begin
                        state_d = ST_IDLE;
                        index_d = '0;
                        presc_d = '0;
                    end else if (presc_end) begin
                        presc_d = '0;
                        if (state_q == ST_SHOW) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_SHOW;
                            index_d = last_slot ? '0 : index_q + IW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state register
    always_comb begin
        digit_d  = '0;
        blank_d  = 1'b1;
        last_idx = IW'(count_d - CW'(1));

        case (state_d)
            ST_IDLE: begin
                blank_d = (count_d == '0);
                if (count_d != '0) begin
                    // A digit being written this cycle is not yet in buf_q
                    digit_d = wr_en ? input_nibble : buf_q[last_idx];
                end
            end
            ST_SHOW: begin
                blank_d = 1'b0;
                digit_d = buf_q[index_d];
            end
            ST_GAP: begin
                blank_d = 1'b1;
                digit_d = buf_q[index_d];
            end
            default: begin
                blank_d = 1'b1;
                digit_d = '0;
            end
        endcase
    end

    assign output_digit    = digit_q;
    assign output_blank    = blank_q;
    assign output_index    = index_q;
    assign output_count    = count_q;
    assign output_full     = (count_q == CW'(DEPTH));
    assign output_overflow = ovf_q;

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Testbench for hex_digit_sequencer: directed scenarios plus randomized
// traffic, checked against a playback-timeline reference model through a
// cycle-tagged scoreboard queue.
module tb_hex_digit_sequencer;

    localparam int DEPTH = 4;
    localparam int TICK  = 4;

    logic       clk = 1'b0;
    logic       input_reset = 1'b0;
    logic [3:0] input_nibble = '0;
    logic       input_load = 1'b0;
    logic       input_run = 1'b0;
    logic       input_clear = 1'b0;
    logic [3:0] output_digit;
    logic       output_blank;
    logic [1:0] output_index;
    logic [2:0] output_count;
    logic       output_full;
    logic       output_overflow;

    hex_digit_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
        .input_clock_50 (clk),
        .input_reset    (input_reset),
        .input_nibble   (input_nibble),
        .input_load     (input_load),
        .input_run      (input_run),
        .input_clear    (input_clear),
        .output_digit   (output_digit),
        .output_blank   (output_blank),
        .output_index   (output_index),
        .output_count   (output_count),
        .output_full    (output_full),
        .output_overflow(output_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] digit;
        logic       blank;
        int         idx;
        int         cnt;
        logic       full;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    // Reference model: buffer as a queue, playback as elapsed time t
    logic [3:0] mq[$];
    bit         playing = 0;
    int         t = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input bit rst, input bit clr, input bit ld,
                        input logic [3:0] nib, input bit run);
        exp_t e;
        bit   ovf;
        int   n;
        @(negedge clk);
        input_reset  = rst;
        input_clear  = clr;
        input_load   = ld;
        input_nibble = nib;
        input_run    = run;
        ovf = 0;
        if (rst || clr) begin
            mq.delete();
            playing = 0;
            t = 0;
        end else if (playing) begin
            if (!run) playing = 0;
            else t++;
        end else if (ld) begin
            if (mq.size() < DEPTH) mq.push_back(nib);
            else ovf = 1;
        end else if (run && mq.size() > 0) begin
            playing = 1;
            t = 0;
        end
        n = mq.size();
        if (playing) begin
            e.idx   = (t / (2 * TICK)) % n;
            e.digit = mq[e.idx];
            e.blank = ((t / TICK) % 2) == 1;
        end else begin
            e.idx   = 0;
            e.blank = (n == 0);
            e.digit = (n > 0) ? mq[n-1] : 4'h0;
        end
        e.cnt  = n;
        e.full = (n == DEPTH);
        e.ovf  = ovf;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each cycle's outputs against the entry due that cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (output_digit !== e.digit || output_blank !== e.blank ||
                int'(output_index) != e.idx || int'(output_count) != e.cnt ||
                output_full !== e.full || output_overflow !== e.ovf) begin
                fails++;
                $display("FAIL cyc%0d: got digit=%h blank=%b idx=%0d cnt=%0d full=%b ovf=%b, want digit=%h blank=%b idx=%0d cnt=%0d full=%b ovf=%b",
                         cyc, output_digit, output_blank, output_index, output_count,
                         output_full, output_overflow, e.digit, e.blank, e.idx,
                         e.cnt, e.full, e.ovf);
            end
        end
    end

    initial begin
        logic [3:0] seq[5];
        bit         run_lvl;

        // Reset state
        step(1, 0, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(0, 0, 0, 4'h0, 0);

        // Load two digits, idle shows the last one
        step(0, 0, 1, 4'h3, 0);
        step(0, 0, 1, 4'hA, 0);
        step(0, 0, 0, 4'h0, 0);

        // Fill the buffer then overflow
        step(0, 1, 0, 4'h0, 0);
        seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3; seq[3] = 4'h4; seq[4] = 4'hF;
        for (int i = 0; i < 5; i++) step(0, 0, 1, seq[i], 0);
        step(0, 0, 0, 4'h0, 0);
        step(0, 0, 1, 4'h9, 1);
        step(0, 0, 0, 4'h0, 0);

        // Playback of {1,2,3} with wrap
        step(0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, seq[i], 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 4'h0, 0);

        // Run with an empty buffer stays idle and blank
        step(0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 4'h0, 0);

        // Clear together with load during SHOW of digit 2
        for (int i = 0; i < 3; i++) step(0, 0, 1, seq[i], 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 4'h0, 1);
        step(0, 1, 1, 4'h7, 1);
        step(0, 0, 0, 4'h0, 0);
        step(0, 0, 0, 4'h0, 0);

        // Reset on prescaler cycle 2 of SHOW, then run with no loads
        for (int i = 0; i < 2; i++) step(0, 0, 1, seq[i+1], 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 1);
        step(1, 0, 0, 4'h0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 4'h0, 1);

        // Randomized traffic
        run_lvl = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 99) < 6) run_lvl = ~run_lvl;
            step(r == 0, (r >= 1 && r <= 2), (r >= 3 && r <= 20),
                 4'($urandom_range(0, 15)), run_lvl);
        end
        step(0, 0, 0, 4'h0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
